// File: rtl/dmem_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_mmio_responder
// Purpose  : CPU data-port responder with a word RAM and a 16-byte MMIO page
//            (console TX FIFO, cycle counter, halt/exit register).
//            Optional macro DMEM_STORE_CNT_EN adds a committed-store counter.
// Revision : 1.0  initial release
// ============================================================================
// mask encoding: 2'b00 byte, 2'b01 halfword, 2'b10/2'b11 word.
module dmem_mmio_responder #(
  parameter int          RAM_WORDS  = 1024,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_F000,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [1:0]  mask,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        halted,
  output logic [7:0]  exit_code
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam int          CW        = PW + 1;
  localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) * 33'd4;
  localparam logic [1:0]  MASK_BYTE = 2'b00;
  localparam logic [1:0]  MASK_HALF = 2'b01;

  logic [31:0]   ram_mem  [RAM_WORDS];
  logic [7:0]    fifo_mem [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          halted_q, halted_d;
  logic [7:0]    exit_code_q, exit_code_d;
  logic [31:0]   cycle_q, cycle_d;

  logic          ram_sel, mmio_sel, store_en;
  logic          ram_we, push_req, push_ok, pop, halt_we, full, empty;
  logic [AW-1:0] ram_idx;
  logic [3:0]    ram_be;
  logic [31:0]   ram_wdata;

  assign ram_sel  = ({1'b0, a} < RAM_BYTES);
  assign mmio_sel = (a[31:4] == MMIO_BASE[31:4]);
  assign ram_idx  = a[AW+1:2];
  assign store_en = we & ~halted_q;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign pop      = ~empty & tx_ready;
  assign push_req = store_en & mmio_sel & (a[3:2] == 2'd0);
  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign push_ok  = push_req & (~full | pop);
  assign halt_we  = store_en & mmio_sel & (a[3:2] == 2'd2);
  assign ram_we   = store_en & ram_sel;

  assign tx_valid  = ~empty;
  assign tx_data   = empty ? 8'h00 : fifo_mem[rd_ptr_q];
  assign halted    = halted_q;
  assign exit_code = exit_code_q;

  always_comb begin
    ram_be    = 4'hF;
    ram_wdata = wd;
    case (mask)
      MASK_BYTE: begin
        ram_be    = 4'b0001 << a[1:0];
        ram_wdata = {4{wd[7:0]}};
      end
      MASK_HALF: begin
        ram_be    = a[1] ? 4'b1100 : 4'b0011;
        ram_wdata = {2{wd[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_be[i]) ram_mem[ram_idx][8*i +: 8] <= ram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= wd[7:0];
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q + PW'(push_ok);
    rd_ptr_d    = rd_ptr_q + PW'(pop);
    count_d     = count_q;
    overflow_d  = overflow_q | (push_req & full & ~pop);
    halted_d    = halted_q;
    exit_code_d = exit_code_q;
    cycle_d     = cycle_q + 32'd1;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: ;
    endcase
    if (halt_we) begin
      halted_d    = 1'b1;
      exit_code_d = wd[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      halted_q    <= 1'b0;
      exit_code_q <= 8'h00;
      cycle_q     <= 32'h0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      halted_q    <= halted_d;
      exit_code_q <= exit_code_d;
      cycle_q     <= cycle_d;
    end
  end

`ifdef DMEM_STORE_CNT_EN
  logic [31:0] store_cnt_q, store_cnt_d;

  always_comb begin
    store_cnt_d = store_cnt_q + 32'(ram_we | push_ok | halt_we);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) store_cnt_q <= 32'h0;
    else        store_cnt_q <= store_cnt_d;
  end
`endif

  always_comb begin
    rd = 32'h0;
    if (ram_sel) begin
      rd = ram_mem[ram_idx];
    end else if (mmio_sel) begin
      case (a[3:2])
        2'd0:    rd = {16'h0, 8'(count_q), 5'b0, overflow_q, full, empty};
        2'd1:    rd = cycle_q;
        2'd2:    rd = {23'h0, halted_q, exit_code_q};
`ifdef DMEM_STORE_CNT_EN
        default: rd = store_cnt_q;
`else
        default: rd = 32'h0;
`endif
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
- Data-memory responder serving the CPU's data port (memory_address / memory_write / memory_mask / memory_we / memory_out).
- Backs a word-organised RAM and adds a small MMIO page:
  - console TX FIFO, drained by the bench or host over a valid/ready port
  - free-running cycle counter
  - sticky halt/exit-code register
- Lets program testbenches terminate on a halt condition and check console output instead of running for a fixed time.

Parameters:
- RAM_WORDS, 1024, number of 32-bit RAM words; RAM decodes byte addresses 0 .. RAM_WORDS*4-1.
- MMIO_BASE, 32'hFFFF_F000, base byte address of the 16-byte MMIO page.
- FIFO_DEPTH, 16, console FIFO entries; power of two, 2..256.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- a  in  32  byte address from CPU
- mask  in  memory_mask_t  access size: byte, halfword or word
- we  in  1  store strobe
- wd  in  32  store data, right-aligned (byte in [7:0], halfword in [15:0])
- rd  out  32  load data
- tx_valid  out  1  FIFO non-empty
- tx_data  out  8  FIFO head byte
- tx_ready  in  1  consumer accepts head
- halted  out  1  sticky halt flag
- exit_code  out  8  code latched with halt

Behaviour:
- Reset (async, rst_n=0): FIFO emptied; tx_valid=0, tx_data=0; halted=0, exit_code=0; cycle counter=0; overflow flag=0. RAM contents are not reset. rd follows the combinational decode.
- Loads are combinational, same cycle: rd = aligned word at a[31:2]. Byte/halfword extraction is the CPU's job.
- Stores commit on the rising edge when we=1.
- RAM store lanes, by access size:
  - byte: writes lane a[1:0] with wd[7:0].
  - halfword: writes lanes {a[1],0} and {a[1],1} with wd[15:0].
  - word: writes all lanes with wd.
  - Misaligned halfword/word stores ignore the low address bits.
- MMIO decode uses a[3:2] within the page; any access size is allowed.
- MMIO +0x0 CONSOLE:
  - Store pushes wd[7:0]. If the FIFO is full and no pop happens that cycle, the byte is dropped and overflow is set (sticky until reset).
  - Load returns {16'b0, count[7:0], 5'b0, overflow, full, empty}.
- MMIO +0x4 CYCLE:
  - Load returns a 32-bit counter, incremented every cycle after reset, wrapping 32'hFFFF_FFFF -> 0.
  - Stores are ignored.
- MMIO +0x8 HALT:
  - Store sets halted=1 and exit_code=wd[7:0].
  - Load returns {23'b0, halted, exit_code}.
- MMIO +0xC: see Optional Feature.
- Any other address: loads return 0, stores are ignored.
- Once halted=1: every later store (RAM and MMIO, including HALT) is ignored. Loads, FIFO drain and the cycle counter keep running.
- FIFO handshake:
  - Pop on a rising edge when tx_valid && tx_ready.
  - tx_data is stable while tx_valid=1 and not popped.
  - A pushed byte is visible on tx_valid one cycle after the store edge; there is no fall-through.
- Simultaneous push and pop:
  - When full: both succeed, count unchanged, no overflow.
  - When empty: push succeeds, pop does nothing (tx_valid was 0).
- FIFO pointers wrap modulo FIFO_DEPTH. Count ranges 0..FIFO_DEPTH.
- rst_n asserted mid-operation clears all of the above immediately. Pending FIFO data is lost.

Optional Feature:
- Macro DMEM_STORE_CNT_EN.
- Defined: MMIO +0xC is a 32-bit read-only count of committed stores (RAM and MMIO, excluding stores dropped after halt or by overflow). It resets to 0 and wraps.
- Undefined: +0xC reads 0, stores to it are ignored, and no counter logic is built.

Test Plan:
- RAM byte/half/word: word store 0xDEADBEEF at 0x10, then byte store 0x55 at 0x13, then halfword store 0x1234 at 0x10 -> load at 0x10 returns 0x55AD1234.
- Console ordering and latency: stores 'H' then 'i' to MMIO_BASE with tx_ready=1 -> tx_valid rises one cycle after the first store; tx_data is 0x48 then 0x69; FIFO is empty afterwards and the status load returns 0x00000001.
- Overflow and concurrent pop: tx_ready=0, push 17 bytes (depth 16) -> status returns 0x00001006 and the first 16 bytes are retained. Then a push while tx_ready=1 with the FIFO full -> count stays 16 and the byte is accepted.
- Halt lockout: store 0x2A to +0x8 -> halted=1 and exit_code=0x2A next cycle. A later RAM store to 0x20 does not change it, and a store of 0x07 to +0x8 leaves exit_code=0x2A.
- Cycle counter and reset: load +0x4 at two points N cycles apart -> difference is N. Pulse rst_n low mid-test with the FIFO holding 3 bytes -> tx_valid=0, halted=0 and the counter restarts at 0.
- DMEM_STORE_CNT_EN: with the macro defined, 5 RAM stores and 1 console store -> +0xC reads 6. With it undefined -> +0xC reads 0.
